// File: rtl/user_event_gen_pkg.sv
// Shared tetris event codes and button indexing for the user input front end.
// Code 0 means "no event"; button indices are ordered lowest to highest priority.
package user_event_gen_pkg;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_NEW_GAME = 3'd5
  } user_event_t;

  localparam int NUM_BTN      = 5;
  localparam int BTN_RIGHT    = 0;
  localparam int BTN_LEFT     = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_ROTATE   = 3;
  localparam int BTN_NEW_GAME = 4;

  function automatic user_event_t btn_event(input int idx);
    case (idx)
      BTN_RIGHT:    return EV_RIGHT;
      BTN_LEFT:     return EV_LEFT;
      BTN_DOWN:     return EV_DOWN;
      BTN_ROTATE:   return EV_ROTATE;
      BTN_NEW_GAME: return EV_NEW_GAME;
      default:      return EV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/user_event_gen_btn_debounce.sv
// Two-flop synchronizer, down-counting debouncer and registered rise pulse
// for one raw asynchronous button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt reaching zero on a differing sample means DEBOUNCE_CYCLES in a row differed
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= LOAD;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= LOAD;
      end else if (cnt == '0) begin
        level <= sync[1];
        rise  <= sync[1];
        cnt   <= LOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/user_event_gen.sv
// Debounced buttons -> priority arbiter -> small event FIFO for the game logic.
// Define USER_EVENT_AUTOREPEAT_EN to autorepeat LEFT/RIGHT/DOWN while held.
module user_event_gen
  import user_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_down_i,
  input  logic       btn_rotate_i,
  input  logic       btn_new_game_i,
  input  logic       user_event_rd_req_i,
  output logic [2:0] user_event_o,
  output logic       user_event_ready_o,
  output logic       overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    $error("FIFO_DEPTH must be a power of two >= 2");
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    $error("DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");

  logic [NUM_BTN-1:0] btn_raw, btn_level, btn_rise, rpt_hit, pending, grant;
  user_event_t        sel_event;
  user_event_t        mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               pop, full, any_pending, wr, drop;

  assign btn_raw = {btn_new_game_i, btn_rotate_i, btn_down_i, btn_left_i, btn_right_i};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .level (btn_level[i]),
      .rise  (btn_rise[i])
    );
  end

`ifdef USER_EVENT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  // Only the movement buttons (indices below ROTATE) repeat
  for (genvar i = 0; i < BTN_ROTATE; i++) begin : g_rpt
    logic [RW-1:0] rpt_cnt;
    always_ff @(posedge clk) begin
      if (rst || !btn_level[i])
        rpt_cnt <= RW'(REPEAT_DELAY - 1);
      else if (rpt_cnt == '0)
        rpt_cnt <= RW'(REPEAT_PERIOD - 1);
      else
        rpt_cnt <= rpt_cnt - 1'b1;
    end
    assign rpt_hit[i] = btn_level[i] && (rpt_cnt == '0);
  end
  assign rpt_hit[NUM_BTN-1:BTN_ROTATE] = '0;
`else
  assign rpt_hit = '0;
`endif

  // Later (higher-index) buttons override, giving NEW_GAME top priority
  always_comb begin
    grant     = '0;
    sel_event = EV_NONE;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pending[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        sel_event = btn_event(i);
      end
    end
  end

  assign pop         = user_event_rd_req_i && (count != '0);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign any_pending = |pending;
  assign wr          = any_pending && (!full || pop);
  assign drop        = any_pending && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | btn_rise | rpt_hit;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= sel_event;
  end

  assign user_event_ready_o = (count != '0);
  assign user_event_o       = (count != '0) ? mem[rd_ptr] : EV_NONE;

endmodule

// File: tb/tb_user_event_gen.sv
// Directed self-checking bench for user_event_gen with default parameters.
module tb_user_event_gen;
  import user_event_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_left, btn_right, btn_down, btn_rotate, btn_new_game;
  logic       rd_req;
  logic [2:0] ev;
  logic       ready, ovf;

  int checks = 0;
  int errors = 0;
  int n_down;

  always #5 clk = ~clk;

  user_event_gen dut (
    .clk                 (clk),
    .rst                 (rst),
    .btn_left_i          (btn_left),
    .btn_right_i         (btn_right),
    .btn_down_i          (btn_down),
    .btn_rotate_i        (btn_rotate),
    .btn_new_game_i      (btn_new_game),
    .user_event_rd_req_i (rd_req),
    .user_event_o        (ev),
    .user_event_ready_o  (ready),
    .overflow_o          (ovf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      BTN_RIGHT:    btn_right    = v;
      BTN_LEFT:     btn_left     = v;
      BTN_DOWN:     btn_down     = v;
      BTN_ROTATE:   btn_rotate   = v;
      default:      btn_new_game = v;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    wait_cyc(22);
    set_btn(idx, 1'b0);
    wait_cyc(22);
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    wait_cyc(1);
    rd_req = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input user_event_t e);
    chk({tag, "_ready"}, 8'(ready), 8'd1);
    chk({tag, "_event"}, 8'(ev), 8'(e));
    pop_one();
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0;
    btn_left = 0; btn_right = 0; btn_down = 0; btn_rotate = 0; btn_new_game = 0;
    wait_cyc(3);
    chk("reset_ready", 8'(ready), 8'd0);
    chk("reset_event", 8'(ev), 8'd0);
    chk("reset_ovf", 8'(ovf), 8'd0);
    rst = 1'b0;
    wait_cyc(2);

    // clean left press: first sampling edge is edge 0, ready after edge 19
    btn_left = 1'b1;
    wait_cyc(19);
    chk("left_edge18_ready", 8'(ready), 8'd0);
    wait_cyc(1);
    chk("left_edge19_ready", 8'(ready), 8'd1);
    chk("left_edge19_event", 8'(ev), 8'(EV_LEFT));
    pop_one();
    chk("left_pop_ready", 8'(ready), 8'd0);
    chk("left_pop_event", 8'(ev), 8'd0);
    btn_left = 1'b0;
    wait_cyc(30);
    chk("release_no_event", 8'(ready), 8'd0);
    pop_one();
    chk("empty_rd_ignored", 8'(ready), 8'd0);

    // bouncing rotate never settles long enough
    for (int i = 0; i < 40; i++) begin
      btn_rotate = ((i / 3) % 2) == 0;
      wait_cyc(1);
    end
    btn_rotate = 1'b0;
    chk("bounce_mid_ready", 8'(ready), 8'd0);
    wait_cyc(30);
    chk("bounce_end_ready", 8'(ready), 8'd0);

    // simultaneous presses arbitrate by priority
    btn_left = 1'b1; btn_new_game = 1'b1; btn_rotate = 1'b1;
    wait_cyc(25);
    btn_left = 1'b0; btn_new_game = 1'b0; btn_rotate = 1'b0;
    pop_expect("simul_0", EV_NEW_GAME);
    pop_expect("simul_1", EV_ROTATE);
    pop_expect("simul_2", EV_LEFT);
    chk("simul_empty", 8'(ready), 8'd0);
    wait_cyc(25);

    // fill to 4, then a write that lands on the same edge as a pop
    press(BTN_NEW_GAME);
    press(BTN_ROTATE);
    press(BTN_DOWN);
    press(BTN_LEFT);
    chk("full_ovf_before", 8'(ovf), 8'd0);
    btn_right = 1'b1;
    wait_cyc(19);
    rd_req = 1'b1;
    wait_cyc(1);
    rd_req = 1'b0;
    chk("full_popwr_ovf", 8'(ovf), 8'd0);
    btn_right = 1'b0;
    wait_cyc(25);
    pop_expect("full_0", EV_ROTATE);
    pop_expect("full_1", EV_DOWN);
    pop_expect("full_2", EV_LEFT);
    pop_expect("full_3", EV_RIGHT);
    chk("full_empty", 8'(ready), 8'd0);

    // six presses into a depth-4 queue with no pops
    press(BTN_NEW_GAME);
    press(BTN_ROTATE);
    press(BTN_DOWN);
    press(BTN_LEFT);
    press(BTN_RIGHT);
    press(BTN_NEW_GAME);
    chk("ovf_set", 8'(ovf), 8'd1);
    pop_expect("ovf_0", EV_NEW_GAME);
    pop_expect("ovf_1", EV_ROTATE);
    pop_expect("ovf_2", EV_DOWN);
    pop_expect("ovf_3", EV_LEFT);
    chk("ovf_empty", 8'(ready), 8'd0);
    chk("ovf_sticky", 8'(ovf), 8'd1);

    // reset with 3 queued and left pending; left stays held through reset
    press(BTN_NEW_GAME);
    press(BTN_ROTATE);
    press(BTN_DOWN);
    btn_left = 1'b1;
    wait_cyc(19);
    chk("rst_pre_head", 8'(ev), 8'(EV_NEW_GAME));
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("rst_ready", 8'(ready), 8'd0);
    chk("rst_ovf", 8'(ovf), 8'd0);
    wait_cyc(10);
    chk("rst_no_stale", 8'(ready), 8'd0);
    wait_cyc(15);
    chk("rst_fresh_ready", 8'(ready), 8'd1);
    chk("rst_fresh_event", 8'(ev), 8'(EV_LEFT));
    btn_left = 1'b0;
    pop_one();
    wait_cyc(25);
    chk("rst_drained", 8'(ready), 8'd0);

    // down held: debounced high ~87 cycles spans two repeat points
    btn_down = 1'b1;
    wait_cyc(88);
    btn_down = 1'b0;
    wait_cyc(40);
    n_down = 0;
    for (int k = 0; k < 6; k++) begin
      if (ready) begin
        if (ev == EV_DOWN) n_down++;
        pop_one();
      end
    end
`ifdef USER_EVENT_AUTOREPEAT_EN
    chk("hold_down_count", 8'(n_down), 8'd3);
`else
    chk("hold_down_count", 8'(n_down), 8'd1);
`endif
    chk("hold_empty", 8'(ready), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
